// File: rtl/fetch_align_pkg.sv
// Types and constants for the fetch realignment queue.
//   FETCH_HW                    : halfwords per 64-bit fetch word
//   QUEUE_DEPTH                 : number of 16-bit queue entries (power of 2, >= 8)
//   AlignEntryType              : one queued halfword with its pc and fault flags
//   fetch_align_queue_registers : complete register state of the queue
//   is_rvc()                    : true when a leading halfword starts a 16-bit instr
package fetch_align_pkg;
  import river_cfg_pkg::*;

  localparam int FETCH_HW    = 4;
  localparam int QUEUE_DEPTH = 8;
  localparam int PTR_W       = $clog2(QUEUE_DEPTH);
  localparam int CNT_W       = PTR_W + 1;

  typedef struct packed {
    logic [15:0]           hw;
    logic [RISCV_ARCH-1:0] pc;
    logic                  load_fault;
    logic                  page_fault_x;
  } AlignEntryType;

  // Packed so the whole register set can be cleared with a single '0.
  typedef struct packed {
    AlignEntryType [QUEUE_DEPTH-1:0] q;
    logic [PTR_W-1:0]                rd_ptr;
    logic [PTR_W-1:0]                wr_ptr;
    logic [CNT_W-1:0]                count;
  } fetch_align_queue_registers;

  // A halfword whose low two bits are not 2'b11 encodes a compressed instruction.
  function automatic logic is_rvc(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage : fetch_align_pkg

// File: rtl/river_cfg_pkg.sv
// River core configuration constants shared across the fetch pipeline.
//   RISCV_ARCH : width of program-counter and address datapaths.
package river_cfg_pkg;

  localparam int RISCV_ARCH = 64;

endpackage : river_cfg_pkg

// File: rtl/fetch_align_queue.sv
// Halfword-granular realignment queue between the I-cache fetch port and the
// decoder. Incoming 64-bit fetch words are split into halfword entries starting
// at the halfword selected by i_pc[2:1]. The head of the queue is decoded into
// one RVC (16-bit) or RV (32-bit) instruction per cycle, including RV
// instructions whose two halves arrived in different fetch words.
//
// Ports
//   i_clk, i_nrst      clock, asynchronous active-low reset
//   i_flush            redirect: empty the queue and drop same-cycle input
//   i_valid/o_in_ready fetch word handshake
//   i_pc               byte address of the first valid halfword (bit 0 = 0)
//   i_data             8-byte aligned fetch word
//   i_load_fault       fetch access fault for this word
//   i_page_fault_x     fetch page fault for this word
//   o_valid/i_ready    decoder handshake for the head instruction
//   o_pc               pc of the head instruction
//   o_instr            instruction; RVC in [15:0] with [31:16] = 0
//   o_compressed       head instruction is RVC
//   o_load_fault       load fault on any halfword used by the head instruction
//   o_page_fault_x     page fault on any halfword used by the head instruction
//
// Queue depth is fixed by fetch_align_pkg::QUEUE_DEPTH because the register
// struct in the package is sized by it.
module fetch_align_queue
  import river_cfg_pkg::*;
  import fetch_align_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_in_ready,
  input  logic [RISCV_ARCH-1:0] i_pc,
  input  logic [63:0]           i_data,
  input  logic                  i_load_fault,
  input  logic                  i_page_fault_x,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [RISCV_ARCH-1:0] o_pc,
  output logic [31:0]           o_instr,
  output logic                  o_compressed,
  output logic                  o_load_fault,
  output logic                  o_page_fault_x
);

  localparam int DEPTH = QUEUE_DEPTH;

  fetch_align_queue_registers r;
  fetch_align_queue_registers rin;

  AlignEntryType    head;
  logic [PTR_W-1:0] nxt_idx;
  logic [15:0]      nxt_hw;
  logic             nxt_load_fault;
  logic             nxt_page_fault_x;
  logic             head_fault;
  logic             nxt_fault;

  logic             out_valid;
  logic [1:0]       pop_size;
  logic [31:0]      out_instr;
  logic             out_compressed;
  logic             out_load_fault;
  logic             out_page_fault_x;

  logic             in_ready;
  logic             in_fault;
  logic [1:0]       in_off;
  logic [2:0]       push_n;
  logic             push_en;
  logic             pop_en;
  logic [2:0]       push_cnt;
  logic [1:0]       pop_cnt;
  logic [15:0]      in_hw [FETCH_HW];

  // Room for a full word is judged on the registered count only; a pop in the
  // same cycle does not make room, which keeps o_in_ready off the decoder's
  // i_ready path.
  always_comb begin
    in_ready = (DEPTH - int'(r.count)) >= FETCH_HW;
  end

  // Split the incoming word into halfwords and work out how many entries it
  // contributes. A faulting word carries no usable data, so it collapses into
  // a single marker entry that still carries the pc and the fault flags.
  always_comb begin
    for (int k = 0; k < FETCH_HW; k++) begin
      in_hw[k] = i_data[16*k +: 16];
    end
    in_fault = i_load_fault | i_page_fault_x;
    in_off   = i_pc[2:1];
    push_n   = in_fault ? 3'd1 : (3'd4 - {1'b0, in_off});
    push_en  = i_valid & in_ready & ~i_flush;
    push_cnt = push_en ? push_n : 3'd0;
  end

  // Head decode looks only at registered entries (no input bypass). A fault
  // entry is checked before the RVC test because its zeroed halfword would
  // otherwise look like a compressed instruction. An RV instruction needs its
  // second halfword present; a lone upper half simply waits.
  always_comb begin
    head             = r.q[r.rd_ptr];
    nxt_idx          = r.rd_ptr + PTR_W'(1);
    nxt_hw           = r.q[nxt_idx].hw;
    nxt_load_fault   = r.q[nxt_idx].load_fault;
    nxt_page_fault_x = r.q[nxt_idx].page_fault_x;
    head_fault       = head.load_fault | head.page_fault_x;
    nxt_fault        = nxt_load_fault | nxt_page_fault_x;

    out_valid        = 1'b0;
    pop_size         = 2'd0;
    out_instr        = 32'h0;
    out_compressed   = 1'b0;
    out_load_fault   = 1'b0;
    out_page_fault_x = 1'b0;

    if (r.count != '0) begin
      if (head_fault) begin
        out_valid        = 1'b1;
        pop_size         = 2'd1;
        out_load_fault   = head.load_fault;
        out_page_fault_x = head.page_fault_x;
      end else if (is_rvc(head.hw)) begin
        out_valid      = 1'b1;
        pop_size       = 2'd1;
        out_instr      = {16'h0, head.hw};
        out_compressed = 1'b1;
      end else if (r.count >= CNT_W'(2)) begin
        out_valid = 1'b1;
        pop_size  = 2'd2;
        if (nxt_fault) begin
          out_load_fault   = nxt_load_fault;
          out_page_fault_x = nxt_page_fault_x;
        end else begin
          out_instr = {nxt_hw, head.hw};
        end
      end
    end

    pop_en  = out_valid & i_ready & ~i_flush;
    pop_cnt = pop_en ? pop_size : 2'd0;
  end

  // Next-state: flush wins over everything and rewinds both pointers to zero;
  // otherwise write the pushed halfwords at wr_ptr (wrapping naturally through
  // the pointer width) and advance pointers and count by what moved.
  always_comb begin
    rin = r;
    if (i_flush) begin
      rin.rd_ptr = '0;
      rin.wr_ptr = '0;
      rin.count  = '0;
    end else begin
      if (push_en) begin
        for (int k = 0; k < FETCH_HW; k++) begin
          if (k < int'(push_n)) begin
            rin.q[r.wr_ptr + PTR_W'(k)].hw           = in_fault ? 16'h0 : in_hw[2'(int'(in_off) + k)];
            rin.q[r.wr_ptr + PTR_W'(k)].pc           = i_pc + RISCV_ARCH'(2 * k);
            rin.q[r.wr_ptr + PTR_W'(k)].load_fault   = i_load_fault;
            rin.q[r.wr_ptr + PTR_W'(k)].page_fault_x = i_page_fault_x;
          end
        end
      end
      rin.wr_ptr = r.wr_ptr + PTR_W'(push_cnt);
      rin.rd_ptr = r.rd_ptr + PTR_W'(pop_cnt);
      rin.count  = r.count + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
    end
  end

  // State register; reset clears the storage as well so every data output
  // reads zero straight out of reset.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r <= '0;
    end else begin
      r <= rin;
    end
  end

  // Data outputs are held at zero whenever nothing is presented so the
  // decoder never sees stale entries.
  always_comb begin
    o_in_ready     = in_ready;
    o_valid        = out_valid;
    o_pc           = out_valid ? head.pc : '0;
    o_instr        = out_instr;
    o_compressed   = out_compressed;
    o_load_fault   = out_load_fault;
    o_page_fault_x = out_page_fault_x;
  end

endmodule : fetch_align_queue

// File: tb/tb_fetch_align_queue.sv
// Self-checking bench for fetch_align_queue: directed scenarios with
// constant expectations followed by randomized traffic compared against a
// halfword-queue reference model.
module tb_fetch_align_queue;

  logic        i_clk;
  logic        i_nrst;
  logic        i_flush;
  logic        i_valid;
  logic        o_in_ready;
  logic [63:0] i_pc;
  logic [63:0] i_data;
  logic        i_load_fault;
  logic        i_page_fault_x;
  logic        o_valid;
  logic        i_ready;
  logic [63:0] o_pc;
  logic [31:0] o_instr;
  logic        o_compressed;
  logic        o_load_fault;
  logic        o_page_fault_x;

  int vectors = 0;
  int miscompares = 0;

  fetch_align_queue dut (
    .i_clk         (i_clk),
    .i_nrst        (i_nrst),
    .i_flush       (i_flush),
    .i_valid       (i_valid),
    .o_in_ready    (o_in_ready),
    .i_pc          (i_pc),
    .i_data        (i_data),
    .i_load_fault  (i_load_fault),
    .i_page_fault_x(i_page_fault_x),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_pc          (o_pc),
    .o_instr       (o_instr),
    .o_compressed  (o_compressed),
    .o_load_fault  (o_load_fault),
    .o_page_fault_x(o_page_fault_x)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [15:0] hw;
    logic [63:0] pc;
    logic        lf;
    logic        pf;
  } ref_ent_t;

  ref_ent_t    mq[$];
  logic        exp_valid;
  int          exp_size;
  logic        exp_in_ready;
  logic [63:0] exp_pc;
  logic [31:0] exp_instr;
  logic        exp_comp;
  logic        exp_lf;
  logic        exp_pf;

  // What the decoder should see given the halfwords currently queued.
  function automatic void model_head();
    exp_valid    = 1'b0;
    exp_size     = 0;
    exp_pc       = 64'h0;
    exp_instr    = 32'h0;
    exp_comp     = 1'b0;
    exp_lf       = 1'b0;
    exp_pf       = 1'b0;
    exp_in_ready = (8 - mq.size()) >= 4;
    if (mq.size() == 0) return;
    exp_pc = mq[0].pc;
    if (mq[0].lf || mq[0].pf) begin
      exp_valid = 1'b1; exp_size = 1; exp_lf = mq[0].lf; exp_pf = mq[0].pf;
    end else if (mq[0].hw[1:0] != 2'b11) begin
      exp_valid = 1'b1; exp_size = 1; exp_comp = 1'b1; exp_instr = {16'h0, mq[0].hw};
    end else if (mq.size() >= 2) begin
      exp_valid = 1'b1; exp_size = 2;
      if (mq[1].lf || mq[1].pf) begin
        exp_lf = mq[1].lf; exp_pf = mq[1].pf;
      end else begin
        exp_instr = {mq[1].hw, mq[0].hw};
      end
    end
    if (!exp_valid) exp_pc = 64'h0;
  endfunction

  // Advance the model across one clock edge using the expectations computed
  // before that edge.
  function automatic void model_clock(input logic v, input logic fl, input logic rdy,
                                      input logic [63:0] pc, input logic [63:0] data,
                                      input logic lf, input logic pf);
    ref_ent_t e;
    int off;
    if (fl) begin
      mq.delete();
      return;
    end
    if (exp_valid && rdy) begin
      for (int i = 0; i < exp_size; i++) void'(mq.pop_front());
    end
    if (v && exp_in_ready) begin
      if (lf || pf) begin
        e.hw = 16'h0; e.pc = pc; e.lf = lf; e.pf = pf;
        mq.push_back(e);
      end else begin
        off = int'(pc[2:1]);
        for (int k = off; k < 4; k++) begin
          e.hw = data[16*k +: 16];
          e.pc = pc + 64'(2 * (k - off));
          e.lf = 1'b0; e.pf = 1'b0;
          mq.push_back(e);
        end
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_word(input logic v, input logic [63:0] pc, input logic [63:0] data,
                          input logic lf, input logic pf);
    i_valid = v; i_pc = pc; i_data = data; i_load_fault = lf; i_page_fault_x = pf;
  endtask

  task automatic do_flush();
    i_valid = 1'b0; i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %0b expected 0", o_valid); end
    vectors++; if (o_in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", o_in_ready); end
    vectors++; if (o_pc !== 64'h0) begin miscompares++; $display("[TB] FAIL reset_pc: got %h expected 0", o_pc); end
    vectors++; if (o_instr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_instr: got %h expected 0", o_instr); end
    vectors++; if (o_compressed !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_compressed: got %0b expected 0", o_compressed); end
    vectors++; if ({o_load_fault, o_page_fault_x} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_faults: got %b expected 00", {o_load_fault, o_page_fault_x}); end
    repeat (2) @(posedge i_clk);
    #1;
    i_nrst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    i_ready = 1'b1;
    set_word(1'b1, 64'h1000, 64'h00B5_0513_4501_4581, 1'b0, 1'b0);
    tick();
    i_valid = 1'b0;
    vectors++; if (o_valid !== 1'b1 || o_instr !== 32'h4581 || o_pc !== 64'h1000 || o_compressed !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_hw0: got v=%0b %h @%h c=%0b expected v=1 00004581 @1000 c=1", o_valid, o_instr, o_pc, o_compressed); end
    tick();
    vectors++; if (o_valid !== 1'b1 || o_instr !== 32'h4501 || o_pc !== 64'h1002 || o_compressed !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_hw1: got v=%0b %h @%h c=%0b expected v=1 00004501 @1002 c=1", o_valid, o_instr, o_pc, o_compressed); end
    tick();
    vectors++; if (o_valid !== 1'b1 || o_instr !== 32'h00B50513 || o_pc !== 64'h1004 || o_compressed !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_rv: got v=%0b %h @%h c=%0b expected v=1 00b50513 @1004 c=0", o_valid, o_instr, o_pc, o_compressed); end
    tick();
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_empty: got %0b expected 0", o_valid); end
  endtask

  task automatic test_straddle();
    i_ready = 1'b1;
    set_word(1'b1, 64'h2006, 64'h0513_0000_0000_0000, 1'b0, 1'b0);
    tick();
    i_valid = 1'b0;
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL straddle_stall: got %0b expected 0", o_valid); end
    tick();
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL straddle_stall_hold: got %0b expected 0", o_valid); end
    set_word(1'b1, 64'h2008, 64'h4501_4501_4501_00B5, 1'b0, 1'b0);
    tick();
    i_valid = 1'b0;
    vectors++; if (o_valid !== 1'b1 || o_instr !== 32'h00B50513 || o_pc !== 64'h2006 || o_compressed !== 1'b0) begin miscompares++; $display("[TB] FAIL straddle_join: got v=%0b %h @%h c=%0b expected v=1 00b50513 @2006 c=0", o_valid, o_instr, o_pc, o_compressed); end
    tick();
    vectors++; if (o_valid !== 1'b1 || o_pc !== 64'h200A) begin miscompares++; $display("[TB] FAIL straddle_after: got v=%0b @%h expected v=1 @200a", o_valid, o_pc); end
    do_flush();
  endtask

  task automatic test_fault();
    i_ready = 1'b1;
    set_word(1'b1, 64'h3000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    tick();
    i_valid = 1'b0; i_page_fault_x = 1'b0;
    vectors++; if (o_valid !== 1'b1 || o_instr !== 32'h0 || o_pc !== 64'h3000 || o_page_fault_x !== 1'b1 || o_load_fault !== 1'b0 || o_compressed !== 1'b0) begin miscompares++; $display("[TB] FAIL fault_head: got v=%0b %h @%h pf=%0b lf=%0b c=%0b expected v=1 0 @3000 pf=1 lf=0 c=0", o_valid, o_instr, o_pc, o_page_fault_x, o_load_fault, o_compressed); end
    tick();
    vectors++; if (o_valid !== 1'b0 || o_in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL fault_drained: got v=%0b rdy=%0b expected v=0 rdy=1", o_valid, o_in_ready); end
  endtask

  task automatic test_full();
    i_ready = 1'b0;
    set_word(1'b1, 64'h4000, 64'h4581_4581_4581_4581, 1'b0, 1'b0);
    tick();
    vectors++; if (o_in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL full_half: got %0b expected 1", o_in_ready); end
    i_pc = 64'h4008;
    tick();
    vectors++; if (o_in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_ready: got %0b expected 0", o_in_ready); end
    i_pc = 64'h4010;
    tick();
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      vectors++; if (o_valid !== 1'b1 || o_pc !== 64'h4000 + 64'(2 * i) || o_in_ready !== (i >= 4)) begin miscompares++; $display("[TB] FAIL full_drain[%0d]: got v=%0b @%h rdy=%0b expected v=1 @%h rdy=%0b", i, o_valid, o_pc, o_in_ready, 64'h4000 + 64'(2 * i), (i >= 4)); end
      tick();
    end
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL full_third_dropped: got %0b expected 0", o_valid); end
  endtask

  task automatic test_flush();
    i_ready = 1'b0;
    set_word(1'b1, 64'h5000, 64'h4581_4581_4581_4581, 1'b0, 1'b0);
    tick();
    vectors++; if (o_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_pre: got %0b expected 1", o_valid); end
    i_pc = 64'h5008; i_ready = 1'b1; i_flush = 1'b1;
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    vectors++; if (o_valid !== 1'b0 || o_in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_clear: got v=%0b rdy=%0b expected v=0 rdy=1", o_valid, o_in_ready); end
    tick();
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_push_dropped: got %0b expected 0", o_valid); end
  endtask

  task automatic test_async_reset();
    i_ready = 1'b0;
    set_word(1'b1, 64'h6000, 64'h4581_4581_4581_4581, 1'b0, 1'b0);
    tick();
    i_pc = 64'h6006;
    tick();
    i_valid = 1'b0;
    vectors++; if (o_valid !== 1'b1 || o_in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_pre: got v=%0b rdy=%0b expected v=1 rdy=0", o_valid, o_in_ready); end
    #2 i_nrst = 1'b0;
    #1;
    vectors++; if (o_valid !== 1'b0 || o_in_ready !== 1'b1 || o_pc !== 64'h0) begin miscompares++; $display("[TB] FAIL areset_now: got v=%0b rdy=%0b pc=%h expected v=0 rdy=1 pc=0", o_valid, o_in_ready, o_pc); end
    @(negedge i_clk);
    i_nrst = 1'b1;
    tick();
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_after: got %0b expected 0", o_valid); end
  endtask

  task automatic test_random();
    logic        v, fl, rdy, lf, pf;
    logic [63:0] pc, data;
    logic [15:0] hw;
    mq.delete();
    for (int c = 0; c < 800; c++) begin
      model_head();
      vectors++; if (o_valid !== exp_valid) begin miscompares++; $display("[TB] FAIL rnd_valid cyc %0d: got %0b expected %0b", c, o_valid, exp_valid); end
      vectors++; if (o_in_ready !== exp_in_ready) begin miscompares++; $display("[TB] FAIL rnd_in_ready cyc %0d: got %0b expected %0b", c, o_in_ready, exp_in_ready); end
      if (exp_valid) begin
        vectors++; if (o_pc !== exp_pc || o_instr !== exp_instr || o_compressed !== exp_comp) begin miscompares++; $display("[TB] FAIL rnd_head cyc %0d: got %h @%h c=%0b expected %h @%h c=%0b", c, o_instr, o_pc, o_compressed, exp_instr, exp_pc, exp_comp); end
        vectors++; if (o_load_fault !== exp_lf || o_page_fault_x !== exp_pf) begin miscompares++; $display("[TB] FAIL rnd_faults cyc %0d: got lf=%0b pf=%0b expected lf=%0b pf=%0b", c, o_load_fault, o_page_fault_x, exp_lf, exp_pf); end
      end
      v   = $urandom_range(0, 9) < 6;
      rdy = $urandom_range(0, 9) < 7;
      fl  = $urandom_range(0, 39) == 0;
      lf  = $urandom_range(0, 19) == 0;
      pf  = $urandom_range(0, 19) == 0;
      pc  = {32'h0, 32'($urandom())};
      pc[0] = 1'b0;
      data = 64'h0;
      for (int k = 0; k < 4; k++) begin
        hw = 16'($urandom());
        if ($urandom_range(0, 1) == 1) hw[1:0] = 2'b11;
        data[16*k +: 16] = hw;
      end
      set_word(v, pc, data, lf, pf);
      i_flush = fl;
      i_ready = rdy;
      tick();
      model_clock(v, fl, rdy, pc, data, lf, pf);
    end
    i_valid = 1'b0; i_flush = 1'b0;
  endtask

  initial begin
    i_nrst = 1'b1;
    i_flush = 1'b0;
    i_ready = 1'b0;
    set_word(1'b0, 64'h0, 64'h0, 1'b0, 1'b0);
    #1 i_nrst = 1'b0;
    #2;
    test_reset();
    test_basic();
    test_straddle();
    test_fault();
    test_full();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_fetch_align_queue
